// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and defaults for the Data_Memory port arbiter
package mem_arb_pkg;
  localparam int ADDR_W_DEF       = 32;
  localparam int DATA_W_DEF       = 256;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_D    = 2'd1,
    OWN_I    = 2'd2
  } arb_owner_e;
endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner select between D and I requesters
// favor_i_i carries the policy history (starvation escape or round-robin turn) from the top.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       d_req_i,
  input  logic       i_req_i,
  input  logic       favor_i_i,
  output arb_owner_e grant_o
);

  always_comb begin
    grant_o = OWN_NONE;
    if (i_req_i && (!d_req_i || favor_i_i)) begin
      grant_o = OWN_I;
    end else if (d_req_i) begin
      grant_o = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the Data_Memory port between D-cache and I-refill requesters
// Define ARB_RR_EN for strict round-robin; default is D priority with a starvation escape for I.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              d_req_i,
  input  logic              d_write_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_data_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_data_o,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_ack_o,
  output logic [DATA_W-1:0] i_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              busy_o
);

  arb_state_e        state_q;
  arb_owner_e        owner_q;
  arb_owner_e        grant;
  logic              en_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              favor_i;
  logic              grant_now;

  assign grant_now = (state_q == ST_IDLE) && (grant != OWN_NONE);

  mem_arb_pick u_pick (
    .d_req_i   (d_req_i),
    .i_req_i   (i_req_i),
    .favor_i_i (favor_i),
    .grant_o   (grant)
  );

`ifdef ARB_RR_EN
  // Reset value "last was I" makes the first tie after reset go to D.
  logic last_i_q;
  logic last_i_d;

  assign favor_i  = ~last_i_q;
  assign last_i_d = grant_now ? (grant == OWN_I) : last_i_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) last_i_q <= 1'b1;
    else        last_i_q <= last_i_d;
  end
`else
  localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;

  assign favor_i = (starve_q >= CNT_MAX);

  always_comb begin
    starve_d = starve_q;
    if (grant_now) begin
      if (grant == OWN_I) begin
        starve_d = '0;
      end else if (i_req_i && (starve_q != CNT_MAX)) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
      en_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant != OWN_NONE) begin
            state_q <= ST_BUSY;
            owner_q <= grant;
            en_q    <= 1'b1;
            if (grant == OWN_D) begin
              wr_q   <= d_write_i;
              addr_q <= d_addr_i;
              data_q <= d_data_i;
            end else begin
              wr_q   <= 1'b0;
              addr_q <= i_addr_i;
              data_q <= '0;
            end
          end
        end
        ST_BUSY: begin
          if (mem_ack_i) begin
            state_q <= ST_DONE;
            owner_q <= OWN_NONE;
            en_q    <= 1'b0;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: begin
          state_q <= ST_IDLE;
          owner_q <= OWN_NONE;
          en_q    <= 1'b0;
        end
      endcase
    end
  end

  // A requester that let go mid-transaction gets neither strobe nor data.
  logic d_route;
  logic i_route;
  assign d_route = (state_q == ST_BUSY) && (owner_q == OWN_D) && d_req_i;
  assign i_route = (state_q == ST_BUSY) && (owner_q == OWN_I) && i_req_i;

  assign d_ack_o      = mem_ack_i & d_route;
  assign i_ack_o      = mem_ack_i & i_route;
  assign d_data_o     = d_route ? mem_data_i : '0;
  assign i_data_o     = i_route ? mem_data_i : '0;
  assign mem_enable_o = en_q;
  assign mem_write_o  = wr_q;
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = data_q;
  assign busy_o       = en_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a 10-cycle memory model
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 256;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          d_req_i, d_write_i, i_req_i;
  logic [AW-1:0] d_addr_i, i_addr_i;
  logic [DW-1:0] d_data_i;
  logic          d_ack_o, i_ack_o;
  logic [DW-1:0] d_data_o, i_data_o;
  logic          mem_enable_o, mem_write_o, busy_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_data_i;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .d_req_i(d_req_i), .d_write_i(d_write_i), .d_addr_i(d_addr_i), .d_data_i(d_data_i),
    .d_ack_o(d_ack_o), .d_data_o(d_data_o),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_ack_o(i_ack_o), .i_data_o(i_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i), .busy_o(busy_o)
  );

  typedef struct {
    logic          is_i;
    logic          chk_data;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model_mem [64];
  logic [DW-1:0] ref_mem   [64];
  int            total = 0;
  int            bad   = 0;
  int            d_acks = 0;
  int            i_acks = 0;

  function automatic void push_exp(input logic is_i, input logic chk, input logic [DW-1:0] dat);
    exp_t e;
    e.is_i = is_i; e.chk_data = chk; e.data = dat;
    sb.push_back(e);
  endfunction

  // Memory model: ack one cycle long, 10 cycles after enable is first seen.
  initial begin : mem_model
    int       cnt;
    logic [5:0] idx;
    cnt = 0;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk_i); #1;
      if (mem_ack_i) begin
        mem_ack_i = 1'b0; mem_data_i = '0; cnt = 0;
      end else if (!rst_i || !mem_enable_o) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt == 10) begin
          idx = mem_addr_o[10:5];
          if (mem_write_o) model_mem[idx] = mem_data_o;
          else             mem_data_i = model_mem[idx];
          mem_ack_i = 1'b1;
          cnt = 0;
        end
      end
    end
  end

  initial begin : monitor
    exp_t          e;
    logic [DW-1:0] obs;
    forever begin
      @(negedge clk_i);
      if (d_ack_o || i_ack_o) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ack d_ack=%0b i_ack=%0b, required no ack", d_ack_o, i_ack_o);
        end else begin
          e = sb.pop_front();
          if ({d_ack_o, i_ack_o} !== (e.is_i ? 2'b01 : 2'b10)) begin
            bad++;
            $display("FAIL ack_owner d_ack=%0b i_ack=%0b, required %s", d_ack_o, i_ack_o, e.is_i ? "I" : "D");
          end
          if (e.chk_data) begin
            total++;
            obs = e.is_i ? i_data_o : d_data_o;
            if (obs !== e.data) begin
              bad++;
              $display("FAIL ack_data got %h required %h", obs, e.data);
            end
          end
        end
        if (d_ack_o) d_acks++;
        if (i_ack_o) i_acks++;
      end
    end
  end

  task automatic d_access(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] dat, output int lat);
    d_write_i = wr; d_addr_i = a; d_data_i = dat; d_req_i = 1'b1; lat = 0;
    while (!d_ack_o && lat < 200) begin @(negedge clk_i); lat++; end
    if (!d_ack_o) begin
      total++; bad++;
      $display("FAIL d_ack_timeout addr=%h no ack within %0d cycles", a, lat);
    end
    #2 d_req_i = 1'b0;
  endtask

  task automatic i_access(input logic [AW-1:0] a, output int lat);
    i_addr_i = a; i_req_i = 1'b1; lat = 0;
    while (!i_ack_o && lat < 200) begin @(negedge clk_i); lat++; end
    if (!i_ack_o) begin
      total++; bad++;
      $display("FAIL i_ack_timeout addr=%h no ack within %0d cycles", a, lat);
    end
    #2 i_req_i = 1'b0;
  endtask

  task automatic wait_level(input logic want, output bit ok);
    int n;
    n = 0;
    while (mem_enable_o !== want && n < 60) begin @(negedge clk_i); n++; end
    ok = (mem_enable_o === want);
  endtask

  task automatic test_reset;
    #1;
    total++;
    if ({mem_enable_o, mem_write_o, busy_o, d_ack_o, i_ack_o} !== 5'b0 ||
        mem_addr_o !== '0 || mem_data_o !== '0 || d_data_o !== '0 || i_data_o !== '0) begin
      bad++;
      $display("FAIL reset_outputs en=%0b wr=%0b busy=%0b addr=%h, required all 0",
               mem_enable_o, mem_write_o, busy_o, mem_addr_o);
    end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    total++;
    if (busy_o !== 1'b0 || mem_enable_o !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset busy=%0b en=%0b, required 0", busy_o, mem_enable_o);
    end
  endtask

  task automatic test_d_read;
    int lat; bit ok; int i0, d0;
    i0 = i_acks; d0 = d_acks;
    push_exp(1'b0, 1'b1, ref_mem[2]);
    fork
      d_access(1'b0, 32'h40, '0, lat);
      begin
        wait_level(1'b1, ok);
        total++;
        if (!ok || mem_addr_o !== 32'h40 || mem_write_o !== 1'b0) begin
          bad++;
          $display("FAIL d_read_issue en=%0b addr=%h wr=%0b, required 1/00000040/0", mem_enable_o, mem_addr_o, mem_write_o);
        end
      end
    join
    total++;
    if (lat !== 10) begin bad++; $display("FAIL d_read_latency got %0d required 10", lat); end
    @(negedge clk_i);
    total++;
    if (i_acks !== i0 || d_acks !== d0 + 1) begin
      bad++;
      $display("FAIL d_read_ack_count d=%0d i=%0d, required d=%0d i=%0d", d_acks - d0, i_acks - i0, 1, 0);
    end
  endtask

  task automatic test_d_write;
    int lat; bit ok; int unstable;
    logic [DW-1:0] w;
    w = {2{128'h0123456789abcdeffedcba9876543210}};
    ref_mem[16] = w;
    push_exp(1'b0, 1'b0, '0);
    unstable = 0;
    fork
      d_access(1'b1, 32'h200, w, lat);
      begin
        wait_level(1'b1, ok);
        while (mem_enable_o) begin
          if (mem_write_o !== 1'b1 || mem_addr_o !== 32'h200 || mem_data_o !== w) unstable++;
          @(negedge clk_i);
        end
      end
    join
    total++;
    if (!ok || unstable != 0) begin
      bad++;
      $display("FAIL d_write_hold unstable_cycles=%0d ok=%0b, required 0 and 1", unstable, ok);
    end
    total++;
    if (model_mem[16] !== w) begin bad++; $display("FAIL d_write_mem got %h required %h", model_mem[16], w); end
    @(negedge clk_i);
    push_exp(1'b0, 1'b1, ref_mem[16]);
    d_access(1'b0, 32'h200, '0, lat);
  endtask

  task automatic test_tie;
    int ld, li, gap; bit ok;
    push_exp(1'b0, 1'b1, ref_mem[4]);
    push_exp(1'b1, 1'b1, ref_mem[31]);
    fork
      d_access(1'b0, 32'h80, '0, ld);
      i_access(32'h3e0, li);
      begin
        wait_level(1'b1, ok);
        total++;
        if (!ok || mem_addr_o !== 32'h80) begin bad++; $display("FAIL tie_first got addr=%h required 00000080", mem_addr_o); end
        wait_level(1'b0, ok);
        gap = 0;
        while (!mem_enable_o && gap < 20) begin @(negedge clk_i); gap++; end
        total++;
        if (gap < 1 || gap > 2 || mem_addr_o !== 32'h3e0 || mem_write_o !== 1'b0) begin
          bad++;
          $display("FAIL tie_second gap=%0d addr=%h wr=%0b, required gap 1..2 addr 000003e0 wr 0", gap, mem_addr_o, mem_write_o);
        end
      end
    join
  endtask

  task automatic test_starve;
    int ld, li, d0, i0;
    d0 = d_acks; i0 = i_acks;
`ifdef ARB_RR_EN
    push_exp(1'b0, 1'b1, ref_mem[1]);
    push_exp(1'b1, 1'b1, ref_mem[63]);
    for (int k = 2; k <= 5; k++) push_exp(1'b0, 1'b1, ref_mem[k]);
`else
    for (int k = 1; k <= 4; k++) push_exp(1'b0, 1'b1, ref_mem[k]);
    push_exp(1'b1, 1'b1, ref_mem[63]);
    push_exp(1'b0, 1'b1, ref_mem[5]);
`endif
    fork
      for (int k = 1; k <= 5; k++) begin
        d_access(1'b0, AW'(k * 32), '0, ld);
        @(negedge clk_i);
      end
      i_access(32'h7e0, li);
    join
    total++;
    if (d_acks !== d0 + 5 || i_acks !== i0 + 1) begin
      bad++;
      $display("FAIL starve_counts d=%0d i=%0d, required d=5 i=1", d_acks - d0, i_acks - i0);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    d_write_i = 1'b0; d_addr_i = 32'h40; d_req_i = 1'b1;
    wait_level(1'b1, ok);
    repeat (5) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    total++;
    if (!ok || {mem_enable_o, busy_o, mem_write_o, d_ack_o, i_ack_o} !== 5'b0 || mem_addr_o !== '0 || d_data_o !== '0) begin
      bad++;
      $display("FAIL reset_mid en=%0b busy=%0b addr=%h ok=%0b, required all 0", mem_enable_o, busy_o, mem_addr_o, ok);
    end
    d_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    mem_ack_i = 1'b1;
    mem_data_i = {8{32'hdeadbeef}};
    #1;
    total++;
    if (d_ack_o !== 1'b0 || i_ack_o !== 1'b0 || d_data_o !== '0) begin
      bad++;
      $display("FAIL stale_ack d_ack=%0b i_ack=%0b, required 0", d_ack_o, i_ack_o);
    end
    repeat (2) @(negedge clk_i);
    total++;
    if (busy_o !== 1'b0 || mem_enable_o !== 1'b0) begin
      bad++;
      $display("FAIL stale_ack_state busy=%0b en=%0b, required 0", busy_o, mem_enable_o);
    end
  endtask

  task automatic test_i_drop;
    bit ok; int n, i0, d0, lat;
    i0 = i_acks;
    i_addr_i = 32'h100; i_req_i = 1'b1;
    wait_level(1'b1, ok);
    repeat (3) @(negedge clk_i);
    i_req_i = 1'b0;
    n = 0;
    while (!mem_ack_i && n < 40) begin @(negedge clk_i); n++; end
    total++;
    if (!ok || !mem_ack_i) begin bad++; $display("FAIL i_drop_mem_complete mem_ack=%0b ok=%0b, required 1", mem_ack_i, ok); end
    wait_level(1'b0, ok);
    @(negedge clk_i);
    total++;
    if (i_acks !== i0) begin bad++; $display("FAIL i_drop_ack got %0d i acks required 0", i_acks - i0); end
    d0 = d_acks;
    push_exp(1'b0, 1'b1, ref_mem[3]);
    d_access(1'b0, 32'h60, '0, lat);
    total++;
    if (d_acks !== d0 + 1 || lat !== 10) begin
      bad++;
      $display("FAIL after_drop_d acks=%0d lat=%0d, required 1 and 10", d_acks - d0, lat);
    end
  endtask

  initial begin
    for (int k = 0; k < 64; k++) begin
      model_mem[k] = {8{32'hecfa0000 + 32'(k)}};
      ref_mem[k]   = {8{32'hecfa0000 + 32'(k)}};
    end
    rst_i = 1'b0;
    d_req_i = 1'b0; d_write_i = 1'b0; d_addr_i = '0; d_data_i = '0;
    i_req_i = 1'b0; i_addr_i = '0;
    test_reset;
    test_d_read;
    @(negedge clk_i);
    test_d_write;
    @(negedge clk_i);
    test_tie;
    repeat (3) @(negedge clk_i);
    test_starve;
    repeat (3) @(negedge clk_i);
    test_reset_mid;
    test_i_drop;
    repeat (3) @(negedge clk_i);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_drain left=%0d required 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
